wbuf_window: RTL and testbench

WBUF_WINDOW -- requirements
Module: wbuf_window

---
 rtl/wbuf_pkg.sv | 16 +
 rtl/wbuf_lane.sv | 84 ++++++++
 rtl/wbuf_window.sv | 111 +++++++++++
 tb/tb_wbuf_window.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wbuf_pkg.sv
// rtl/wbuf_pkg.sv - shared opcodes and default sizes for the window buffer
package wbuf_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_LOAD      = 3'b001,
        OP_SHIFT     = 3'b010,
        OP_LOADSHIFT = 3'b011,
        OP_CLEAR     = 3'b100
    } wbuf_op_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 2;
    localparam int DEF_LANES  = 2;

endpackage

// File: rtl/wbuf_lane.sv
// rtl/wbuf_lane.sv - one shift lane: entries, fill count and full/empty flags
module wbuf_lane
    import wbuf_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    shift,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DEPTH*DATA_W-1:0] entries,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    empty,
    output logic                    full_nxt
);

    logic [DATA_W-1:0] ent_q [DEPTH];
    logic [DATA_W-1:0] ent_d [DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     wr_idx;
    logic              full_q, full_d, empty_q, empty_d;
    logic              has_data;

    // The top only asserts load on a non-full lane and shift on a non-empty
    // lane, except load+shift (LOADSHIFT), which degrades to a plain load when empty.
    always_comb begin
        ent_d    = ent_q;
        cnt_d    = cnt_q;
        has_data = (cnt_q != '0);
        wr_idx   = cnt_q;
        if (clear) begin
            ent_d = '{default: '0};
            cnt_d = '0;
        end else begin
            if (shift && has_data) begin
                for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
                ent_d[DEPTH-1] = '0;
            end
            if (load) begin
                if (shift && has_data) wr_idx = cnt_q - CW'(1);
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) ent_d[i] = wdata;
                end
            end
            case ({load, shift})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                2'b11:   cnt_d = has_data ? cnt_q : CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ent_q   <= '{default: '0};
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign entries[i*DATA_W +: DATA_W] = ent_q[i];
    end

    assign count    = cnt_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign full_nxt = full_d;

endmodule

// File: rtl/wbuf_window.sv
// rtl/wbuf_window.sv - multi-lane window buffer: command decode, handshake, errors
module wbuf_window
    import wbuf_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int LANES  = DEF_LANES,
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [LW-1:0]                 cmd_lane,
    input  logic [LANES*DATA_W-1:0]       lane_data,
    output logic [LANES*DEPTH*DATA_W-1:0] window,
    output logic [LANES*CW-1:0]           lane_count,
    output logic [LANES-1:0]              lane_full,
    output logic [LANES-1:0]              lane_empty,
    output logic                          win_valid,
    output logic                          cmd_err
);

    wbuf_op_e         op;
    logic             accept, lane_ok, sel_full, sel_empty;
    logic [LANES-1:0] lane_sel, lane_load, lane_shift, lane_full_nxt;
    logic             lane_clear;
    logic             cmd_ready_q, cmd_ready_d;
    logic             cmd_err_q, cmd_err_d;
    logic             win_valid_q, win_valid_d;

    assign op = wbuf_op_e'(cmd_op);

    always_comb begin
        lane_load   = '0;
        lane_shift  = '0;
        lane_clear  = 1'b0;
        cmd_err_d   = 1'b0;
        cmd_ready_d = 1'b1;
        accept      = cmd_valid && cmd_ready_q;
        lane_ok     = 32'(cmd_lane) < 32'(LANES);
        for (int k = 0; k < LANES; k++) lane_sel[k] = lane_ok && (LW'(k) == cmd_lane);
        sel_full    = |(lane_sel & lane_full);
        sel_empty   = |(lane_sel & lane_empty);
        if (accept) begin
            case (op)
                OP_NOP: ;
                OP_LOAD: begin
                    if (!lane_ok || sel_full) cmd_err_d = 1'b1;
                    else                      lane_load = lane_sel;
                end
                OP_SHIFT: begin
                    if (!lane_ok || sel_empty) cmd_err_d  = 1'b1;
                    else                       lane_shift = lane_sel;
                end
                OP_LOADSHIFT: begin
                    if (!lane_ok) cmd_err_d = 1'b1;
                    else begin
                        lane_load  = lane_sel;
                        lane_shift = lane_sel;
                    end
                end
                // Clearing all lanes costs one dead cycle on the command port.
                OP_CLEAR: begin
                    lane_clear  = 1'b1;
                    cmd_ready_d = 1'b0;
                end
                default: cmd_err_d = 1'b1;
            endcase
        end
        win_valid_d = &lane_full_nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd_ready_q <= 1'b1;
            cmd_err_q   <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            cmd_err_q   <= cmd_err_d;
            win_valid_q <= win_valid_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        wbuf_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_lane (
            .clk      (clk),
            .nrst     (nrst),
            .clear    (lane_clear),
            .load     (lane_load[k]),
            .shift    (lane_shift[k]),
            .wdata    (lane_data[k*DATA_W +: DATA_W]),
            .entries  (window[k*DEPTH*DATA_W +: DEPTH*DATA_W]),
            .count    (lane_count[k*CW +: CW]),
            .full     (lane_full[k]),
            .empty    (lane_empty[k]),
            .full_nxt (lane_full_nxt[k])
        );
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_err   = cmd_err_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_wbuf_window.sv
// tb/tb_wbuf_window.sv - scoreboard bench for default and 4x3 window buffer builds
module tb_wbuf_window;
    import wbuf_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic        c2_valid = 1'b0, c2_ready, c2_lane = 1'b0;
    logic [2:0]  c2_op = '0;
    logic [15:0] c2_data = '0;
    logic [31:0] w2;
    logic [3:0]  cnt2;
    logic [1:0]  full2, empty2;
    logic        wv2, err2;

    logic        c4_valid = 1'b0, c4_ready;
    logic [1:0]  c4_lane = 2'd2;
    logic [2:0]  c4_op = '0;
    logic [31:0] c4_data = '0;
    logic [95:0] w4;
    logic [11:0] cnt4;
    logic [3:0]  full4, empty4;
    logic        wv4, err4;

    wbuf_window u_dut (
        .clk(clk), .nrst(nrst), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_op(c2_op), .cmd_lane(c2_lane), .lane_data(c2_data), .window(w2),
        .lane_count(cnt2), .lane_full(full2), .lane_empty(empty2),
        .win_valid(wv2), .cmd_err(err2)
    );

    wbuf_window #(.DATA_W(8), .DEPTH(3), .LANES(4)) u_dut4 (
        .clk(clk), .nrst(nrst), .cmd_valid(c4_valid), .cmd_ready(c4_ready),
        .cmd_op(c4_op), .cmd_lane(c4_lane), .lane_data(c4_data), .window(w4),
        .lane_count(cnt4), .lane_full(full4), .lane_empty(empty4),
        .win_valid(wv4), .cmd_err(err4)
    );

    typedef struct {
        int                    due;
        bit                    big;
        string                 nm;
        logic [3:0][2:0][7:0]  e;
        logic [3:0][2:0]       c;
        bit                    err;
        bit                    rdy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, string f, logic [95:0] act, logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", nm, f, act, exp);
        end
    endfunction

    exp_t        x;
    logic [95:0] ew, ec;
    logic [3:0]  ef, ee;
    logic        ewv;
    int          nl, nd, ncw;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x   = sb.pop_front();
            nl  = x.big ? 4 : 2;
            nd  = x.big ? 3 : 2;
            ncw = x.big ? 3 : 2;
            ew  = '0; ec = '0; ef = '0; ee = '0; ewv = 1'b1;
            for (int k = 0; k < nl; k++) begin
                for (int i = 0; i < nd; i++) ew[(k*nd+i)*8 +: 8] = x.e[k][i];
                for (int b = 0; b < ncw; b++) ec[k*ncw+b] = x.c[k][b];
                ef[k] = (int'(x.c[k]) == nd);
                ee[k] = (x.c[k] == 3'd0);
                ewv   = ewv & ef[k];
            end
            if (x.big) begin
                chk(x.nm, "window",    w4,          ew);
                chk(x.nm, "count",     96'(cnt4),   ec);
                chk(x.nm, "full",      96'(full4),  96'(ef));
                chk(x.nm, "empty",     96'(empty4), 96'(ee));
                chk(x.nm, "win_valid", 96'(wv4),    96'(ewv));
                chk(x.nm, "cmd_err",   96'(err4),   96'(x.err));
                chk(x.nm, "cmd_ready", 96'(c4_ready), 96'(x.rdy));
            end else begin
                chk(x.nm, "window",    96'(w2),     ew);
                chk(x.nm, "count",     96'(cnt2),   ec);
                chk(x.nm, "full",      96'(full2),  96'(ef));
                chk(x.nm, "empty",     96'(empty2), 96'(ee));
                chk(x.nm, "win_valid", 96'(wv2),    96'(ewv));
                chk(x.nm, "cmd_err",   96'(err2),   96'(x.err));
                chk(x.nm, "cmd_ready", 96'(c2_ready), 96'(x.rdy));
            end
        end
    end

    task automatic push_rst(input int due, input string nm);
        exp_t r;
        r.due = due; r.nm = nm; r.e = '0; r.c = '0; r.err = 1'b0; r.rdy = 1'b1;
        r.big = 1'b0; sb.push_back(r);
        r.big = 1'b1; sb.push_back(r);
    endtask

    task automatic step2(input bit v, input logic [2:0] op, input bit ln, input logic [7:0] d,
                         input logic [7:0] a0, a1, b0, b1, input int ca, cb,
                         input bit err, rdy, input string nm);
        exp_t r;
        c2_valid = v; c2_op = op; c2_lane = ln;
        c2_data  = ln ? {d, 8'hA5} : {8'h5A, d};
        r.due = cyc + 1; r.big = 1'b0; r.nm = nm;
        r.e = '0; r.e[0][0] = a0; r.e[0][1] = a1; r.e[1][0] = b0; r.e[1][1] = b1;
        r.c = '0; r.c[0] = 3'(ca); r.c[1] = 3'(cb);
        r.err = err; r.rdy = rdy;
        sb.push_back(r);
        @(posedge clk); #1;
        c2_valid = 1'b0;
    endtask

    task automatic step4(input logic [2:0] op, input logic [7:0] d, input logic [7:0] e0, e1, e2,
                         input int cnt, input bit err, input string nm);
        exp_t r;
        c4_valid = 1'b1; c4_op = op; c4_lane = 2'd2;
        c4_data  = {8'hA5, d, 8'hA5, 8'hA5};
        r.due = cyc + 1; r.big = 1'b1; r.nm = nm;
        r.e = '0; r.e[2][0] = e0; r.e[2][1] = e1; r.e[2][2] = e2;
        r.c = '0; r.c[2] = 3'(cnt);
        r.err = err; r.rdy = 1'b1;
        sb.push_back(r);
        @(posedge clk); #1;
        c4_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push_rst(cyc, "reset");
        @(posedge clk); #1;
        nrst = 1'b1;

        step2(1, OP_LOAD,      0, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, "load0_11");
        step2(1, OP_LOAD,      0, 8'h22, 8'h11, 8'h22, 8'h00, 8'h00, 2, 0, 0, 1, "load0_22");
        step2(1, OP_LOAD,      1, 8'h33, 8'h11, 8'h22, 8'h33, 8'h00, 2, 1, 0, 1, "load1_33");
        step2(1, OP_LOAD,      1, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 2, 2, 0, 1, "load1_44");
        step2(1, OP_LOAD,      1, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 2, 2, 1, 1, "load_full_err");
        step2(1, OP_LOADSHIFT, 0, 8'h99, 8'h22, 8'h99, 8'h33, 8'h44, 2, 2, 0, 1, "ldsh_full");
        step2(1, OP_SHIFT,     0, 8'h00, 8'h99, 8'h00, 8'h33, 8'h44, 1, 2, 0, 1, "shift1");
        step2(1, OP_SHIFT,     0, 8'h00, 8'h00, 8'h00, 8'h33, 8'h44, 0, 2, 0, 1, "shift2");
        step2(1, OP_SHIFT,     0, 8'h00, 8'h00, 8'h00, 8'h33, 8'h44, 0, 2, 1, 1, "shift_empty_err");
        step2(1, OP_LOADSHIFT, 0, 8'h7A, 8'h7A, 8'h00, 8'h33, 8'h44, 1, 2, 0, 1, "ldsh_empty");
        step2(1, OP_NOP,       0, 8'hFF, 8'h7A, 8'h00, 8'h33, 8'h44, 1, 2, 0, 1, "nop");
        step2(0, OP_LOAD,      0, 8'hEE, 8'h7A, 8'h00, 8'h33, 8'h44, 1, 2, 0, 1, "idle");
        step2(1, 3'b111,       0, 8'hEE, 8'h7A, 8'h00, 8'h33, 8'h44, 1, 2, 1, 1, "op111");
        step2(1, 3'b101,       1, 8'hEE, 8'h7A, 8'h00, 8'h33, 8'h44, 1, 2, 1, 1, "op101");
        step2(1, OP_LOAD,      0, 8'hBB, 8'h7A, 8'hBB, 8'h33, 8'h44, 2, 2, 0, 1, "load0_bb");
        step2(1, OP_CLEAR,     1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, "clear");
        step2(1, OP_LOAD,      0, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, "blocked");
        step2(1, OP_LOAD,      1, 8'h5C, 8'h00, 8'h00, 8'h5C, 8'h00, 0, 1, 0, 1, "load1_5c");
        step2(1, OP_LOAD,      0, 8'h11, 8'h11, 8'h00, 8'h5C, 8'h00, 1, 1, 0, 1, "pre_rst_a");
        step2(1, OP_LOAD,      0, 8'h22, 8'h11, 8'h22, 8'h5C, 8'h00, 2, 1, 0, 1, "pre_rst_b");

        // Short reset pulse entirely between edges: only an asynchronous reset clears state.
        @(negedge clk); #2;
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        push_rst(cyc + 1, "async_rst");
        @(posedge clk); #1;
        step2(1, OP_LOAD,      0, 8'h66, 8'h66, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, "post_rst_load");

        // Reset held across an edge with a command present: the command is discarded.
        c2_valid = 1'b1; c2_op = OP_LOAD; c2_lane = 1'b1; c2_data = {8'h77, 8'hA5};
        @(negedge clk); #2;
        nrst = 1'b0;
        push_rst(cyc + 1, "rst_discard");
        @(posedge clk); #1;
        c2_valid = 1'b0;
        nrst = 1'b1;
        step2(1, OP_LOAD,      1, 8'h42, 8'h00, 8'h00, 8'h42, 8'h00, 0, 1, 0, 1, "post_rst_load1");

        step4(OP_LOAD,      8'h11, 8'h11, 8'h00, 8'h00, 1, 0, "l4_load_11");
        step4(OP_LOAD,      8'h22, 8'h11, 8'h22, 8'h00, 2, 0, "l4_load_22");
        step4(OP_LOAD,      8'h33, 8'h11, 8'h22, 8'h33, 3, 0, "l4_load_33");
        step4(OP_LOAD,      8'h44, 8'h11, 8'h22, 8'h33, 3, 1, "l4_full_err");
        step4(OP_LOADSHIFT, 8'h99, 8'h22, 8'h33, 8'h99, 3, 0, "l4_ldsh");
        step4(OP_SHIFT,     8'h00, 8'h33, 8'h99, 8'h00, 2, 0, "l4_shift1");
        step4(OP_SHIFT,     8'h00, 8'h99, 8'h00, 8'h00, 1, 0, "l4_shift2");
        step4(OP_SHIFT,     8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "l4_shift3");
        step4(OP_SHIFT,     8'h00, 8'h00, 8'h00, 8'h00, 0, 1, "l4_empty_err");
        step4(OP_LOADSHIFT, 8'h7A, 8'h7A, 8'h00, 8'h00, 1, 0, "l4_ldsh_empty");

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
